// File: rtl/hsiao_pkg.sv
// Shared definitions for the Hsiao (13,8) SEC-DED scrubber: field widths,
// data-column syndromes and the controller state encoding.
package hsiao_pkg;

    localparam int CW_W   = 13;
    localparam int DATA_W = 8;
    localparam int PAR_W  = 5;

    // Index i holds the syndrome produced by a flip of data bit i (codeword bit i+5).
    localparam logic [PAR_W-1:0] H_COL [DATA_W] = '{
        5'b00111, 5'b01110, 5'b01101, 5'b01011,
        5'b10011, 5'b10101, 5'b10110, 5'b11001
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CHECK,
        ST_WR_REQ,
        ST_NEXT
    } scrub_state_e;

endpackage

// File: rtl/hsiao_scrub_controller_if.sv
// Shared memory port as seen by one requester; the arbiter grant arrives on mem_gnt.
interface hsiao_scrub_controller_if #(
    parameter int ADDR_W = 8
);
    logic                        mem_req;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [hsiao_pkg::CW_W-1:0]  mem_wdata;
    logic                        mem_gnt;
    logic                        mem_rvalid;
    logic [hsiao_pkg::CW_W-1:0]  mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/hsiao_code_encoder.sv
// Combinational Hsiao parity generator: XOR of the column syndromes of all set data bits.
module hsiao_code_encoder
    import hsiao_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [PAR_W-1:0]  parity
);

    logic [PAR_W-1:0] term [DATA_W];

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_term
            assign term[gi] = data[gi] ? H_COL[gi] : '0;
        end
    endgenerate

    always_comb begin
        parity = '0;
        for (int i = 0; i < DATA_W; i++) begin
            parity = parity ^ term[i];
        end
    end

endmodule

// File: rtl/hsiao_syndrome_decoder.sv
// Combinational SEC-DED decode of one codeword: syndrome, classification and
// the repaired codeword (data bit flipped if a column matched, parity re-encoded).
module hsiao_syndrome_decoder
    import hsiao_pkg::*;
(
    input  logic [CW_W-1:0]  codeword,
    output logic [PAR_W-1:0] syndrome,
    output logic [CW_W-1:0]  corrected,
    output logic             correctable,
    output logic             uncorrectable
);

    logic [DATA_W-1:0] data_in;
    logic [PAR_W-1:0]  check_par;
    logic [DATA_W-1:0] col_hit;
    logic [DATA_W-1:0] fixed_data;
    logic [PAR_W-1:0]  fixed_par;
    logic              single_par;

    assign data_in = codeword[CW_W-1:PAR_W];

    hsiao_code_encoder u_enc_check (
        .data   (data_in),
        .parity (check_par)
    );

    assign syndrome = codeword[PAR_W-1:0] ^ check_par;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_col
            assign col_hit[gi] = (syndrome == H_COL[gi]);
        end
    endgenerate

    // All columns have weight 3, so a column hit already implies odd weight.
    assign single_par    = ($countones(syndrome) == 1);
    assign correctable   = single_par || (|col_hit);
    assign uncorrectable = (syndrome != '0) && !correctable;
    assign fixed_data    = data_in ^ col_hit;

    hsiao_code_encoder u_enc_fix (
        .data   (fixed_data),
        .parity (fixed_par)
    );

    assign corrected = {fixed_data, fixed_par};

endmodule

// File: rtl/hsiao_scrub_controller.sv
// Background scrubber: walks the memory, repairs single-bit errors in place and
// logs/counts uncorrectable words, sharing the memory port through req/gnt.
module hsiao_scrub_controller
    import hsiao_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int INTERVAL_W = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [INTERVAL_W-1:0] interval,
    hsiao_scrub_controller_if.master bus,
    output logic                  err_valid,
    output logic [ADDR_W-1:0]     err_addr,
    output logic                  err_uncorr,
    output logic [CNT_W-1:0]      corr_cnt,
    output logic [CNT_W-1:0]      uncorr_cnt,
    output logic                  pass_done,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    scrub_state_e          state_reg, state_next;
    logic [ADDR_W-1:0]     addr_reg;
    logic [INTERVAL_W-1:0] wait_cnt_reg;
    logic [CW_W-1:0]       cw_reg;
    logic [CW_W-1:0]       wdata_reg;
    logic                  err_valid_reg;
    logic [ADDR_W-1:0]     err_addr_reg;
    logic                  err_uncorr_reg;
    logic [CNT_W-1:0]      corr_cnt_reg;
    logic [CNT_W-1:0]      uncorr_cnt_reg;
    logic                  pass_done_reg;

    logic [PAR_W-1:0]      syndrome;
    logic [CW_W-1:0]       corrected;
    logic                  correctable;
    logic                  uncorrectable;
    logic                  load_wait;

    hsiao_syndrome_decoder u_dec (
        .codeword      (cw_reg),
        .syndrome      (syndrome),
        .corrected     (corrected),
        .correctable   (correctable),
        .uncorrectable (uncorrectable)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A zero interval skips WAIT entirely so back-to-back words have no idle cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = (interval == '0) ? ST_RD_REQ : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt_reg <= INTERVAL_W'(1)) begin
                    state_next = ST_RD_REQ;
                end
            end
            ST_RD_REQ:  if (bus.mem_gnt)    state_next = ST_RD_WAIT;
            ST_RD_WAIT: if (bus.mem_rvalid) state_next = ST_CHECK;
            ST_CHECK:   state_next = correctable ? ST_WR_REQ : ST_NEXT;
            ST_WR_REQ:  if (bus.mem_gnt)    state_next = ST_NEXT;
            ST_NEXT: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = (interval == '0) ? ST_RD_REQ : ST_WAIT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign load_wait = (state_next == ST_WAIT) && (state_reg != ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg       <= '0;
            wait_cnt_reg   <= '0;
            cw_reg         <= '0;
            wdata_reg      <= '0;
            err_valid_reg  <= 1'b0;
            err_addr_reg   <= '0;
            err_uncorr_reg <= 1'b0;
            corr_cnt_reg   <= '0;
            uncorr_cnt_reg <= '0;
            pass_done_reg  <= 1'b0;
        end else begin
            err_valid_reg <= 1'b0;
            pass_done_reg <= 1'b0;

            if (load_wait) begin
                wait_cnt_reg <= interval;
            end else if (state_reg == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg - INTERVAL_W'(1);
            end

            if ((state_reg == ST_RD_WAIT) && bus.mem_rvalid) begin
                cw_reg <= bus.mem_rdata;
            end

            if ((state_reg == ST_CHECK) && (syndrome != '0)) begin
                err_valid_reg  <= 1'b1;
                err_addr_reg   <= addr_reg;
                err_uncorr_reg <= uncorrectable;
                if (correctable) begin
                    wdata_reg <= corrected;
                    if (corr_cnt_reg != '1) corr_cnt_reg <= corr_cnt_reg + CNT_W'(1);
                end else begin
                    if (uncorr_cnt_reg != '1) uncorr_cnt_reg <= uncorr_cnt_reg + CNT_W'(1);
                end
            end

            if (state_reg == ST_NEXT) begin
                if (addr_reg == LAST_ADDR) begin
                    addr_reg      <= '0;
                    pass_done_reg <= 1'b1;
                end else begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                end
            end
        end
    end

    // Request lines decode straight from state so reset drops mem_req immediately.
    assign bus.mem_req   = (state_reg == ST_RD_REQ) || (state_reg == ST_WR_REQ);
    assign bus.mem_we    = (state_reg == ST_WR_REQ);
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;

    assign err_valid  = err_valid_reg;
    assign err_addr   = err_addr_reg;
    assign err_uncorr = err_uncorr_reg;
    assign corr_cnt   = corr_cnt_reg;
    assign uncorr_cnt = uncorr_cnt_reg;
    assign pass_done  = pass_done_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hsiao_scrub_controller.sv
// Directed bench for the scrubber: a memory/arbiter responder model on the bus
// plus hand-computed expectations for clean, correctable and uncorrectable words.
module tb_hsiao_scrub_controller;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;
    localparam int IV_W   = 16;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [IV_W-1:0]   interval;
    logic              err_valid;
    logic [ADDR_W-1:0] err_addr;
    logic              err_uncorr;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;
    logic              pass_done;
    logic              busy;

    hsiao_scrub_controller_if #(.ADDR_W(ADDR_W)) bus ();

    hsiao_scrub_controller #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .INTERVAL_W (IV_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .interval   (interval),
        .bus        (bus.master),
        .err_valid  (err_valid),
        .err_addr   (err_addr),
        .err_uncorr (err_uncorr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt),
        .pass_done  (pass_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Memory model and responder state
    logic [12:0] mem_model [DEPTH];
    int          cyc = 0;
    int          rd_cnt, wr_cnt, pass_cnt, err_cnt;
    int          rd_cyc [DEPTH];
    int          last_raddr, last_waddr;
    logic [12:0] last_wdata;
    int          stall_cfg = 0;
    logic        inject_en = 1'b0;
    logic        rd_pending = 1'b0;
    int          rd_idx = 0;
    logic        in_req = 1'b0;
    int          stall_left = 0;
    logic        granted_prev = 1'b0;
    logic        snap_we;
    logic [7:0]  snap_addr;
    logic [12:0] snap_wdata;

    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                bus.mem_gnt    = 1'b0;
                bus.mem_rvalid = 1'b0;
                rd_pending     = 1'b0;
                in_req         = 1'b0;
                granted_prev   = 1'b0;
                continue;
            end
            if (pass_done) pass_cnt++;
            if (err_valid) begin
                err_cnt++;
                $display("ERR  addr=%0d uncorr=%0d corr_cnt=%0d uncorr_cnt=%0d",
                         err_addr, err_uncorr, corr_cnt, uncorr_cnt);
            end
            if (granted_prev) begin
                check_eq("req_drop_after_gnt", bus.mem_req, 1'b0);
                granted_prev = 1'b0;
            end
            bus.mem_rvalid = 1'b0;
            if (rd_pending) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mem_model[rd_idx];
                rd_pending     = 1'b0;
            end else if (inject_en && !bus.mem_req) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 13'h0001;
            end
            bus.mem_gnt = 1'b0;
            if (in_req) begin
                check_eq("stall_req",   bus.mem_req,   1'b1);
                check_eq("stall_we",    bus.mem_we,    snap_we);
                check_eq("stall_addr",  bus.mem_addr,  snap_addr);
                check_eq("stall_wdata", bus.mem_wdata, snap_wdata);
            end else if (bus.mem_req) begin
                in_req     = 1'b1;
                snap_we    = bus.mem_we;
                snap_addr  = bus.mem_addr;
                snap_wdata = bus.mem_wdata;
                stall_left = stall_cfg;
            end
            if (in_req) begin
                if (stall_left == 0) begin
                    bus.mem_gnt  = 1'b1;
                    in_req       = 1'b0;
                    granted_prev = 1'b1;
                    if (bus.mem_we) begin
                        mem_model[bus.mem_addr[3:0]] = bus.mem_wdata;
                        wr_cnt++;
                        last_waddr = int'(bus.mem_addr);
                        last_wdata = bus.mem_wdata;
                        $display("WR   addr=%0d data=0x%04h", bus.mem_addr, bus.mem_wdata);
                    end else begin
                        rd_pending = 1'b1;
                        rd_idx     = int'(bus.mem_addr[3:0]);
                        rd_cyc[rd_idx] = cyc;
                        rd_cnt++;
                        last_raddr = int'(bus.mem_addr);
                        $display("RD   addr=%0d data=0x%04h", bus.mem_addr, mem_model[rd_idx]);
                    end
                end else begin
                    stall_left--;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        interval  = '0;
        stall_cfg = 0;
        inject_en = 1'b0;
        repeat (2) @(negedge clk);
        rd_cnt   = 0;
        wr_cnt   = 0;
        pass_cnt = 0;
        err_cnt  = 0;
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    // Known-good codewords: data 0x00, 0xFF, 0x01 with their parity.
    task automatic fill_clean();
        for (int i = 0; i < DEPTH; i++) begin
            case (i % 3)
                0:       mem_model[i] = 13'h0000;
                1:       mem_model[i] = 13'h1FE6;
                default: mem_model[i] = 13'h0027;
            endcase
        end
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 3000 && rd_cnt < n; i++) @(negedge clk);
        check_eq("read_count", rd_cnt, n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check_eq("idle", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_words(input int n);
        enable = 1'b1;
        wait_reads(n);
        enable = 1'b0;
        wait_idle();
    endtask

    initial begin : main
        rst_n          = 1'b0;
        enable         = 1'b0;
        interval       = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        fill_clean();

        // Reset state
        do_reset();
        check_eq("rst_req",        bus.mem_req,   1'b0);
        check_eq("rst_addr",       bus.mem_addr,  8'd0);
        check_eq("rst_wdata",      bus.mem_wdata, 13'h0);
        check_eq("rst_busy",       busy,          1'b0);
        check_eq("rst_corr_cnt",   corr_cnt,      4'd0);
        check_eq("rst_uncorr_cnt", uncorr_cnt,    4'd0);
        check_eq("rst_err_addr",   err_addr,      8'd0);
        check_eq("rst_err_uncorr", err_uncorr,    1'b0);

        // Clean pass, back-to-back words
        run_words(16);
        check_eq("t1_writes",     wr_cnt,     0);
        check_eq("t1_pass_done",  pass_cnt,   1);
        check_eq("t1_corr_cnt",   corr_cnt,   4'd0);
        check_eq("t1_uncorr_cnt", uncorr_cnt, 4'd0);
        check_eq("t1_err_pulses", err_cnt,    0);
        check_eq("t1_word_gap",   rd_cyc[1] - rd_cyc[0], 4);

        // Data bit 0 flipped at addr 3
        do_reset();
        fill_clean();
        mem_model[3] = 13'h1FC6;
        run_words(16);
        check_eq("t2_writes",     wr_cnt,       1);
        check_eq("t2_waddr",      last_waddr,   3);
        check_eq("t2_wdata",      last_wdata,   13'h1FE6);
        check_eq("t2_mem3",       mem_model[3], 13'h1FE6);
        check_eq("t2_corr_cnt",   corr_cnt,     4'd1);
        check_eq("t2_uncorr_cnt", uncorr_cnt,   4'd0);
        check_eq("t2_err_addr",   err_addr,     8'd3);
        check_eq("t2_err_uncorr", err_uncorr,   1'b0);
        check_eq("t2_err_pulses", err_cnt,      1);
        check_eq("t2_word_gap",   rd_cyc[4] - rd_cyc[3], 5);

        // Parity bit 0 flipped at addr 5
        do_reset();
        fill_clean();
        mem_model[5] = 13'h1FE7;
        run_words(16);
        check_eq("t3_writes",   wr_cnt,     1);
        check_eq("t3_waddr",    last_waddr, 5);
        check_eq("t3_wdata",    last_wdata, 13'h1FE6);
        check_eq("t3_corr_cnt", corr_cnt,   4'd1);
        check_eq("t3_err_addr", err_addr,   8'd5);

        // Two parity bits flipped at addr 7: detect only
        do_reset();
        fill_clean();
        mem_model[7] = 13'h1FE5;
        run_words(16);
        check_eq("t4_writes",     wr_cnt,       0);
        check_eq("t4_uncorr_cnt", uncorr_cnt,   4'd1);
        check_eq("t4_corr_cnt",   corr_cnt,     4'd0);
        check_eq("t4_err_uncorr", err_uncorr,   1'b1);
        check_eq("t4_err_addr",   err_addr,     8'd7);
        check_eq("t4_mem7",       mem_model[7], 13'h1FE5);

        // Grant held off 5 cycles per request; stray rvalid outside RD_WAIT
        do_reset();
        fill_clean();
        mem_model[1] = 13'h1FC6;
        interval  = 16'd3;
        stall_cfg = 5;
        inject_en = 1'b1;
        run_words(4);
        inject_en = 1'b0;
        check_eq("t5_writes",     wr_cnt,       1);
        check_eq("t5_mem1",       mem_model[1], 13'h1FE6);
        check_eq("t5_corr_cnt",   corr_cnt,     4'd1);
        check_eq("t5_uncorr_cnt", uncorr_cnt,   4'd0);
        check_eq("t5_err_pulses", err_cnt,      1);

        // Reset asserted while a write-back is waiting for its grant
        do_reset();
        fill_clean();
        mem_model[2] = 13'h1FC6;
        stall_cfg = 3;
        enable    = 1'b1;
        begin
            logic seen_wr = 1'b0;
            for (int i = 0; i < 200 && !seen_wr; i++) begin
                @(negedge clk);
                seen_wr = bus.mem_req && bus.mem_we;
            end
            check_eq("t6_wr_req_seen", seen_wr, 1'b1);
        end
        check_eq("t6_corr_before", corr_cnt, 4'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_req_async", bus.mem_req, 1'b0);
        check_eq("t6_corr_rst",  corr_cnt,    4'd0);
        check_eq("t6_busy_rst",  busy,        1'b0);
        check_eq("t6_mem2_kept", mem_model[2], 13'h1FC6);
        repeat (2) @(negedge clk);
        stall_cfg = 0;
        rd_cnt    = 0;
        wr_cnt    = 0;
        rst_n     = 1'b1;
        wait_reads(1);
        check_eq("t6_restart_addr", last_raddr, 0);
        enable = 1'b0;
        wait_idle();

        // Every word correctable: the corrected count must saturate, not wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 13'h1FC6;
        run_words(16);
        check_eq("t7_writes",     wr_cnt,        16);
        check_eq("t7_corr_sat",   corr_cnt,      4'hF);
        check_eq("t7_uncorr_cnt", uncorr_cnt,    4'd0);
        check_eq("t7_mem15",      mem_model[15], 13'h1FE6);
        check_eq("t7_pass_done",  pass_cnt,      1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
